cache_ctrl: RTL

//  Upstream controller for the cache set array. Accepts CPU read/write requests and drives compare

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_word_ctr.sv | 34 +++
 rtl/cache_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared state encoding, line geometry and address-field helpers for the cache controller.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB_RD,
        WB_MEM,
        ALLOC_RD,
        ALLOC_WR,
        DONE
    } cache_state_t;

    localparam int unsigned WORD_W     = 2;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned STAT_W     = 16;

    // Address layout is {tag, index, word}; these give the low bit of each field.
    localparam int unsigned WORD_LSB   = 0;
    localparam int unsigned INDEX_LSB  = WORD_LSB + WORD_W;

    function automatic int unsigned tag_lsb(input int unsigned index_w);
        return INDEX_LSB + index_w;
    endfunction

endpackage

// File: rtl/cache_word_ctr.sv
// Word-within-line counter used for writeback and refill sequencing; exposes its next value
// so the controller can register outputs that depend on it.
module cache_word_ctr
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [WORD_W-1:0] count,
    output logic [WORD_W-1:0] count_nxt,
    output logic              last
);

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc) begin
            count_nxt = count + 1'b1;
        end
    end

    assign last = (count == WORD_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// CPU-side cache controller: compare, dirty-victim writeback, line refill and retry.
// Optional hit/miss/writeback counters are enabled with `define CACHE_CTRL_STATS_EN.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter  int unsigned TAG_W   = 5,
    parameter  int unsigned INDEX_W = 3,
    parameter  int unsigned DATA_W  = 16,
    localparam int unsigned ADDR_W  = TAG_W + INDEX_W + WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic [INDEX_W-1:0] set_index,
    output logic               set_enable,
    output logic               set_cmp,
    output logic               set_write,
    output logic [WORD_W-1:0]  set_word,
    output logic [TAG_W-1:0]   set_tag,
    output logic [DATA_W-1:0]  set_data_in,
    output logic               set_valid_in,
    input  logic               set_hit,
    input  logic               set_dirty,
    input  logic               set_valid,
    input  logic               set_ack,
    input  logic [TAG_W-1:0]   set_tag_out,
    input  logic [DATA_W-1:0]  set_data_out,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_hits,
    output logic [STAT_W-1:0]  stat_misses,
    output logic [STAT_W-1:0]  stat_wbacks
`endif
);

    localparam int unsigned TAG_LSB = tag_lsb(INDEX_W);

    cache_state_t       state_q, state_nxt;
    logic               we_q, we_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [DATA_W-1:0]  wdata_q, wdata_nxt;
    logic [DATA_W-1:0]  buf_q, buf_nxt;
    logic [TAG_W-1:0]   vtag_q, vtag_nxt;
    logic [DATA_W-1:0]  rdata_nxt;

    logic               ctr_clr, ctr_inc, ctr_last;
    logic [WORD_W-1:0]  word_q, word_nxt;

    logic [INDEX_W-1:0] index_nxt;
    logic [TAG_W-1:0]   tag_nxt;
    logic               cpu_ack_nxt, set_enable_nxt, set_cmp_nxt, set_write_nxt, set_valid_in_nxt;
    logic [WORD_W-1:0]  set_word_nxt;
    logic [TAG_W-1:0]   set_tag_nxt;
    logic [DATA_W-1:0]  set_data_in_nxt, mem_wdata_nxt;
    logic               mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;

    cache_word_ctr u_word_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ctr_clr),
        .inc       (ctr_inc),
        .count     (word_q),
        .count_nxt (word_nxt),
        .last      (ctr_last)
    );

    always_comb begin
        state_nxt = state_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        buf_nxt   = buf_q;
        vtag_nxt  = vtag_q;
        rdata_nxt = cpu_rdata;
        ctr_clr   = 1'b0;
        ctr_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_nxt    = cpu_we;
                    addr_nxt  = cpu_addr;
                    wdata_nxt = cpu_wdata;
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (set_ack) begin
                    if (set_hit && set_valid) begin
                        if (!we_q) rdata_nxt = set_data_out;
                        state_nxt = DONE;
                    end else begin
                        ctr_clr   = 1'b1;
                        state_nxt = (set_valid && set_dirty) ? WB_RD : ALLOC_RD;
                    end
                end
            end
            WB_RD: begin
                if (set_ack) begin
                    buf_nxt   = set_data_out;
                    vtag_nxt  = set_tag_out;
                    state_nxt = WB_MEM;
                end
            end
            WB_MEM: begin
                if (mem_ack) begin
                    if (ctr_last) begin
                        ctr_clr   = 1'b1;
                        state_nxt = ALLOC_RD;
                    end else begin
                        ctr_inc   = 1'b1;
                        state_nxt = WB_RD;
                    end
                end
            end
            ALLOC_RD: begin
                if (mem_ack) begin
                    buf_nxt   = mem_rdata;
                    state_nxt = ALLOC_WR;
                end
            end
            ALLOC_WR: begin
                if (set_ack) begin
                    if (ctr_last) begin
                        ctr_clr   = 1'b1;
                        state_nxt = COMPARE;
                    end else begin
                        ctr_inc   = 1'b1;
                        state_nxt = ALLOC_RD;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the upcoming state and datapath values.
    always_comb begin
        index_nxt        = addr_nxt[INDEX_LSB +: INDEX_W];
        tag_nxt          = addr_nxt[TAG_LSB +: TAG_W];
        cpu_ack_nxt      = (state_nxt == DONE);
        set_enable_nxt   = (state_nxt inside {COMPARE, WB_RD, ALLOC_WR});
        set_cmp_nxt      = (state_nxt == COMPARE);
        set_write_nxt    = ((state_nxt == COMPARE) && we_nxt) || (state_nxt == ALLOC_WR);
        set_valid_in_nxt = (state_nxt == ALLOC_WR);
        set_word_nxt     = (state_nxt == COMPARE) ? addr_nxt[WORD_LSB +: WORD_W] : word_nxt;
        set_tag_nxt      = (state_nxt inside {COMPARE, ALLOC_WR}) ? tag_nxt : '0;
        set_data_in_nxt  = '0;
        if (state_nxt == COMPARE)  set_data_in_nxt = wdata_nxt;
        if (state_nxt == ALLOC_WR) set_data_in_nxt = buf_nxt;
        mem_req_nxt      = (state_nxt inside {WB_MEM, ALLOC_RD});
        mem_we_nxt       = (state_nxt == WB_MEM);
        mem_addr_nxt     = '0;
        if (state_nxt == WB_MEM)   mem_addr_nxt = {vtag_nxt, index_nxt, word_nxt};
        if (state_nxt == ALLOC_RD) mem_addr_nxt = {tag_nxt, index_nxt, word_nxt};
        mem_wdata_nxt    = (state_nxt == WB_MEM) ? buf_nxt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            vtag_q       <= '0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            set_index    <= '0;
            set_enable   <= 1'b0;
            set_cmp      <= 1'b0;
            set_write    <= 1'b0;
            set_word     <= '0;
            set_tag      <= '0;
            set_data_in  <= '0;
            set_valid_in <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q      <= state_nxt;
            we_q         <= we_nxt;
            addr_q       <= addr_nxt;
            wdata_q      <= wdata_nxt;
            buf_q        <= buf_nxt;
            vtag_q       <= vtag_nxt;
            cpu_ack      <= cpu_ack_nxt;
            cpu_rdata    <= rdata_nxt;
            set_index    <= index_nxt;
            set_enable   <= set_enable_nxt;
            set_cmp      <= set_cmp_nxt;
            set_write    <= set_write_nxt;
            set_word     <= set_word_nxt;
            set_tag      <= set_tag_nxt;
            set_data_in  <= set_data_in_nxt;
            set_valid_in <= set_valid_in_nxt;
            mem_req      <= mem_req_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    // retry_q marks the post-refill compare so it is excluded from the statistics.
    logic retry_q;
    logic first_cmp, hit_evt, miss_evt, wb_evt;

    assign first_cmp = (state_q == COMPARE) && set_ack && !retry_q;
    assign hit_evt   = first_cmp && set_hit && set_valid;
    assign miss_evt  = first_cmp && !(set_hit && set_valid);
    assign wb_evt    = miss_evt && set_valid && set_dirty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q     <= 1'b0;
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbacks <= '0;
        end else begin
            if (state_q == IDLE && cpu_req) begin
                retry_q <= 1'b0;
            end else if (state_q == ALLOC_WR && set_ack && ctr_last) begin
                retry_q <= 1'b1;
            end
            if (hit_evt && stat_hits != '1)    stat_hits   <= stat_hits + 1'b1;
            if (miss_evt && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
            if (wb_evt && stat_wbacks != '1)   stat_wbacks <= stat_wbacks + 1'b1;
        end
    end
`endif

endmodule
